// File: rtl/mux_4_1_arbiter_if.sv
// Request/grant bundle between four requesters and the mux arbiter.
// master = arbiter side, slave = requester side.
interface mux_4_1_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       tout;

  modport master (input req, output gnt, s1, s0, busy, tout);
  modport slave  (output req, input gnt, s1, s0, busy, tout);
endinterface

// File: rtl/mux_4_1_arbiter.sv
// Round-robin owner arbitration for a shared 4:1 mux; drives s1/s0 from the owner index.
// Define MUX_4_1_ARBITER_TIMEOUT_EN to build the MAX_HOLD preemption (hcnt, tout).
//
// state | meaning
// IDLE  | no owner, gnt=0, s1/s0 hold the last owner's index
// GRANT | one requester owns the mux, gnt one-hot
module mux_4_1_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              reset,
  mux_4_1_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [1:0] owner, owner_n;
  logic [3:0] gnt, gnt_n;
  logic [1:0] ptr, ptr_n;
  logic [2:0] pick;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be within 2..255");
  end

  // Returns {found, index}: first set bit of r scanning from p upward, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX_4_1_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hcnt, hcnt_n;
  logic       tout, tout_n;
`endif

  always_comb begin
    state_n = state;
    owner_n = owner;
    gnt_n   = gnt;
    ptr_n   = ptr;
    pick    = '0;
`ifdef MUX_4_1_ARBITER_TIMEOUT_EN
    hcnt_n  = hcnt;
    tout_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        pick = rr_pick(bus.req, ptr);
        if (pick[2]) begin
          state_n = GRANT;
          owner_n = pick[1:0];
          gnt_n   = 4'b0001 << pick[1:0];
        end
`ifdef MUX_4_1_ARBITER_TIMEOUT_EN
        hcnt_n = '0;
`endif
      end
      GRANT: begin
        if (!bus.req[owner]) begin
          ptr_n = owner + 2'd1;
          pick  = rr_pick(bus.req, owner + 2'd1);
          if (pick[2]) begin
            owner_n = pick[1:0];
            gnt_n   = 4'b0001 << pick[1:0];
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
`ifdef MUX_4_1_ARBITER_TIMEOUT_EN
          hcnt_n = '0;
        end else if (hcnt == HOLD_LAST && (bus.req & ~gnt) != 4'b0000) begin
          // Masking the owner guarantees the search lands on another requester.
          ptr_n   = owner + 2'd1;
          pick    = rr_pick(bus.req & ~gnt, owner + 2'd1);
          owner_n = pick[1:0];
          gnt_n   = 4'b0001 << pick[1:0];
          tout_n  = 1'b1;
          hcnt_n  = '0;
        end else if (hcnt != HOLD_LAST) begin
          hcnt_n = hcnt + 8'd1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      gnt   <= '0;
      ptr   <= '0;
`ifdef MUX_4_1_ARBITER_TIMEOUT_EN
      hcnt  <= '0;
      tout  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      owner <= owner_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
`ifdef MUX_4_1_ARBITER_TIMEOUT_EN
      hcnt  <= hcnt_n;
      tout  <= tout_n;
`endif
    end
  end

  assign bus.gnt  = gnt;
  assign bus.s1   = owner[1];
  assign bus.s0   = owner[0];
  assign bus.busy = (state == GRANT);
`ifdef MUX_4_1_ARBITER_TIMEOUT_EN
  assign bus.tout = tout;
`else
  assign bus.tout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Table-driven bench for mux_4_1_arbiter; expected outputs queue up when a vector is
// driven and are popped and compared one edge later.
module tb_mux_4_1_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_4_1_arbiter_if bus ();

  mux_4_1_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       tout;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input string n, input logic r, input logic [3:0] q,
                              input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
    vec_t x;
    x.name = n; x.rst = r; x.req = q; x.gnt = g; x.sel = s; x.busy = b; x.tout = t;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    vec_t e;
    logic [8:0] act, exp;
    @(negedge clk);
    reset   = x.rst;
    bus.req = x.req;
    sb.push_back(x);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    act = {bus.gnt, bus.s1, bus.s0, bus.busy, bus.tout, 1'b0};
    exp = {e.gnt, e.sel, e.busy, e.tout, 1'b0};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b s1s0=%b%b busy=%b tout=%b, want gnt=%b s1s0=%b busy=%b tout=%b",
               e.name, bus.gnt, bus.s1, bus.s0, bus.busy, bus.tout, e.gnt, e.sel, e.busy, e.tout);
    end
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = 4'b0000;

    // reset held with requests pending, then first grant
    tbl.push_back(mk("rst_hold0", 1, 4'b1010, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk("rst_hold1", 1, 4'b1010, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk("rst_first", 0, 4'b1010, 4'b0010, 2'b01, 1, 0));
    tbl.push_back(mk("rst_rel",   0, 4'b0000, 4'b0000, 2'b01, 0, 0));
    // round-robin rotation with 1111
    tbl.push_back(mk("rr_rst",    1, 4'b0000, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk("rr_g0",     0, 4'b1111, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk("rr_h0a",    0, 4'b1111, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk("rr_h0b",    0, 4'b1111, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk("rr_g1",     0, 4'b1110, 4'b0010, 2'b01, 1, 0));
    tbl.push_back(mk("rr_h1a",    0, 4'b1111, 4'b0010, 2'b01, 1, 0));
    tbl.push_back(mk("rr_h1b",    0, 4'b1111, 4'b0010, 2'b01, 1, 0));
    tbl.push_back(mk("rr_g2",     0, 4'b1101, 4'b0100, 2'b10, 1, 0));
    tbl.push_back(mk("rr_h2a",    0, 4'b1111, 4'b0100, 2'b10, 1, 0));
    tbl.push_back(mk("rr_h2b",    0, 4'b1111, 4'b0100, 2'b10, 1, 0));
    tbl.push_back(mk("rr_g3",     0, 4'b1011, 4'b1000, 2'b11, 1, 0));
    tbl.push_back(mk("rr_h3a",    0, 4'b1111, 4'b1000, 2'b11, 1, 0));
    tbl.push_back(mk("rr_h3b",    0, 4'b1111, 4'b1000, 2'b11, 1, 0));
    tbl.push_back(mk("rr_wrap0",  0, 4'b0111, 4'b0001, 2'b00, 1, 0));
    // single requester, release, then a fresh request
    tbl.push_back(mk("sg_rst",    1, 4'b0000, 4'b0000, 2'b00, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk($sformatf("sg_own%0d", i), 0, 4'b0100, 4'b0100, 2'b10, 1, 0));
    tbl.push_back(mk("sg_idle",   0, 4'b0000, 4'b0000, 2'b10, 0, 0));
    tbl.push_back(mk("sg_next",   0, 4'b0001, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk("sg_rel",    0, 4'b0000, 4'b0000, 2'b00, 0, 0));
    // mid-grant reset: ptr is 1 here, requester 3 takes the mux
    tbl.push_back(mk("mr_g3",     0, 4'b1000, 4'b1000, 2'b11, 1, 0));
    tbl.push_back(mk("mr_h3",     0, 4'b1001, 4'b1000, 2'b11, 1, 0));
    tbl.push_back(mk("mr_rst",    1, 4'b1001, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk("mr_g0",     0, 4'b1001, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk("mr_rel",    0, 4'b0000, 4'b0000, 2'b00, 0, 0));

    // hold-limit scenarios, MAX_HOLD=4
    tbl.push_back(mk("to_rst",    1, 4'b0000, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk("to_g1",     0, 4'b0010, 4'b0010, 2'b01, 1, 0));
`ifdef MUX_4_1_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk($sformatf("to_h1_%0d", i), 0, 4'b0110, 4'b0010, 2'b01, 1, 0));
    tbl.push_back(mk("to_pre2",   0, 4'b0110, 4'b0100, 2'b10, 1, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk($sformatf("to_h2_%0d", i), 0, 4'b0110, 4'b0100, 2'b10, 1, 0));
    tbl.push_back(mk("to_pre1",   0, 4'b0110, 4'b0010, 2'b01, 1, 1));
    tbl.push_back(mk("sat_rst",   1, 4'b0000, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk("sat_g0",    0, 4'b0001, 4'b0001, 2'b00, 1, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk($sformatf("sat_h0_%0d", i), 0, 4'b0001, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk("sat_pre2",  0, 4'b0101, 4'b0100, 2'b10, 1, 1));
    tbl.push_back(mk("sat_h2",    0, 4'b0100, 4'b0100, 2'b10, 1, 0));
`else
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk($sformatf("nto_h1_%0d", i), 0, 4'b0110, 4'b0010, 2'b01, 1, 0));
    tbl.push_back(mk("sat_rst",   1, 4'b0000, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk("sat_g0",    0, 4'b0001, 4'b0001, 2'b00, 1, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk($sformatf("sat_h0_%0d", i), 0, 4'b0001, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk("nsat_keep0", 0, 4'b0101, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk("nsat_rel2",  0, 4'b0100, 4'b0100, 2'b10, 1, 0));
`endif

    foreach (tbl[i]) apply(tbl[i]);

    // hand sequence: owner drops and re-raises in the next cycle, no priority kept
    apply(mk("rr_rst2",  1, 4'b0000, 4'b0000, 2'b00, 0, 0));
    apply(mk("rq_g0",    0, 4'b0011, 4'b0001, 2'b00, 1, 0));
    apply(mk("rq_drop0", 0, 4'b0010, 4'b0010, 2'b01, 1, 0));
    apply(mk("rq_back0", 0, 4'b0011, 4'b0010, 2'b01, 1, 0));
    apply(mk("rq_g0b",   0, 4'b0001, 4'b0001, 2'b00, 1, 0));
    apply(mk("rq_idle",  0, 4'b0000, 4'b0000, 2'b00, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
